serial_adder: RTL and testbench



---
 rtl/serial_adder.sv | 138 +++++++++++++
 tb/tb_serial_adder.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder with a START/BUSY/DONE handshake; one operand bit pair per cycle, LSB first.
// Optional feature: define SERIAL_ADDER_OVF_EN to add the registered two's-complement overflow output OVF.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CIN,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] SUM,
  output logic             COUT
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             OVF
`endif
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  if (WIDTH < 2) begin : g_width_check
    $error("serial_adder: WIDTH must be at least 2");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0] a_sh, b_sh, res_sh, res_nx;
  logic [CW-1:0]    cnt;
  logic             carry, carry_nx;
  logic             s1, c1, bit_s, c2;
  logic             accept, last_bit;
  logic             busy_q, done_q, cout_q;
  logic [WIDTH-1:0] sum_q;

  // START is only honoured outside SHIFT, so a busy adder never restarts.
  assign accept   = START && (state != ST_SHIFT);
  assign last_bit = (state == ST_SHIFT) && (cnt == CNT_LAST);

  // Two cascaded half adders form the full-adder cell for the current bit.
  always_comb begin
    s1       = a_sh[0] ^ b_sh[0];
    c1       = a_sh[0] & b_sh[0];
    bit_s    = s1 ^ carry;
    c2       = s1 & carry;
    carry_nx = c1 | c2;
    res_nx   = {bit_s, res_sh[WIDTH-1:1]};
  end

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:  if (START) state_nx = ST_SHIFT;
      ST_SHIFT: if (last_bit) state_nx = ST_DONE;
      ST_DONE:  state_nx = START ? ST_SHIFT : ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // NOTE: the datapath registers are reset too, so an aborted operation leaves nothing behind.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      busy_q <= (state_nx == ST_SHIFT);
      done_q <= last_bit;
      if (accept) begin
        a_sh   <= A;
        b_sh   <= B;
        carry  <= CIN;
        res_sh <= '0;
        cnt    <= '0;
      end else if (state == ST_SHIFT) begin
        a_sh   <= a_sh >> 1;
        b_sh   <= b_sh >> 1;
        carry  <= carry_nx;
        res_sh <= res_nx;
        cnt    <= cnt + CW'(1);
        if (last_bit) begin
          sum_q  <= res_nx;
          cout_q <= carry_nx;
        end
      end
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  localparam logic [CW-1:0] CNT_PRE_MSB = CW'(WIDTH - 2);

  logic carry_msb, ovf_q;

  // carry_msb captures the carry leaving bit WIDTH-2, i.e. the carry entering the MSB cycle.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      carry_msb <= 1'b0;
      ovf_q     <= 1'b0;
    end else if (state == ST_SHIFT) begin
      if (cnt == CNT_PRE_MSB) carry_msb <= carry_nx;
      if (last_bit)           ovf_q     <= carry_msb ^ carry_nx;
    end
  end

  assign OVF = ovf_q;
`endif

  assign BUSY = busy_q;
  assign DONE = done_q;
  assign SUM  = sum_q;
  assign COUT = cout_q;

  a_busy_done_exclusive : assert property (@(posedge CLK) disable iff (!RST_N) !(BUSY && DONE));
  a_done_single_pulse   : assert property (@(posedge CLK) disable iff (!RST_N) DONE |=> !DONE);

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8): directed plan vectors, randomized operands,
// ignored mid-operation START, back-to-back START and asynchronous reset abort.
module tb_serial_adder;

  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         RST_N;
  logic         START;
  logic [W-1:0] A, B;
  logic         CIN;
  logic         BUSY, DONE, COUT;
  logic [W-1:0] SUM;
`ifdef SERIAL_ADDER_OVF_EN
  logic         OVF;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  serial_adder #(.WIDTH(W)) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .START(START),
    .A    (A),
    .B    (B),
    .CIN  (CIN),
    .BUSY (BUSY),
    .DONE (DONE),
    .SUM  (SUM),
    .COUT (COUT)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .OVF  (OVF)
`endif
  );

  always #5 CLK = ~CLK;

  // Reference model: plain integer addition.
  function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
    return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
  endfunction

  // Signed overflow: operands share a sign and the result sign differs.
  function automatic logic ref_ovf(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
    logic [W:0] s;
    s = ref_add(a, b, ci);
    return (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
  endfunction

  // Issues a one-cycle START, then waits (bounded) for DONE. lat counts edges after the accepting edge;
  // busy_bad counts cycles before DONE where BUSY was not high.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                       output int lat, output int busy_bad);
    @(negedge CLK);
    A = a; B = b; CIN = ci; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    lat = 0; busy_bad = 0;
    while (!DONE && lat < 3 * W) begin
      if (BUSY !== 1'b1) busy_bad++;
      @(negedge CLK);
      lat++;
    end
  endtask

  task automatic test_reset();
    RST_N = 1'b0; START = 1'b0; A = '0; B = '0; CIN = 1'b0;
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    n_cmp++;
    if ({BUSY, DONE, COUT, SUM} !== {3'b000, {W{1'b0}}}) begin
      n_bad++;
      $display("FAIL reset_state: got busy=%b done=%b cout=%b sum=%h, want all 0", BUSY, DONE, COUT, SUM);
    end
`ifdef SERIAL_ADDER_OVF_EN
    n_cmp++;
    if (OVF !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_ovf: got %b want 0", OVF);
    end
`endif
  endtask

  task automatic check_result(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic ci, input int lat, input int busy_bad);
    logic [W:0] exp;
    exp = ref_add(a, b, ci);
    n_cmp++;
    if (lat != W) begin
      n_bad++;
      $display("FAIL %s_latency: got %0d want %0d", name, lat, W);
    end
    n_cmp++;
    if ({COUT, SUM} !== exp) begin
      n_bad++;
      $display("FAIL %s_sum: a=%h b=%h cin=%b got cout=%b sum=%h want cout=%b sum=%h",
               name, a, b, ci, COUT, SUM, exp[W], exp[W-1:0]);
    end
    n_cmp++;
    if (busy_bad != 0 || BUSY !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_busy: got %0d low-busy cycles, busy_at_done=%b want 0/0", name, busy_bad, BUSY);
    end
`ifdef SERIAL_ADDER_OVF_EN
    n_cmp++;
    if (OVF !== ref_ovf(a, b, ci)) begin
      n_bad++;
      $display("FAIL %s_ovf: got %b want %b", name, OVF, ref_ovf(a, b, ci));
    end
`endif
  endtask

  task automatic test_directed();
    logic [W-1:0] ta [4] = '{8'h35, 8'hFF, 8'h7F, 8'hFF};
    logic [W-1:0] tb [4] = '{8'h4A, 8'h01, 8'h01, 8'hFF};
    logic         tc [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [W:0]   te [4] = '{9'h07F, 9'h100, 9'h080, 9'h1FF};
    int lat, busy_bad;
    for (int i = 0; i < 4; i++) begin
      do_op(ta[i], tb[i], tc[i], lat, busy_bad);
      check_result($sformatf("directed%0d", i), ta[i], tb[i], tc[i], lat, busy_bad);
      n_cmp++;
      if ({COUT, SUM} !== te[i]) begin
        n_bad++;
        $display("FAIL directed%0d_const: got %h want %h", i, {COUT, SUM}, te[i]);
      end
      @(negedge CLK);
      n_cmp++;
      if (DONE !== 1'b0 || {COUT, SUM} !== te[i]) begin
        n_bad++;
        $display("FAIL directed%0d_pulse_hold: got done=%b result=%h want done=0 result=%h",
                 i, DONE, {COUT, SUM}, te[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b;
    logic ci;
    int lat, busy_bad;
    for (int i = 0; i < 40; i++) begin
      a  = W'($urandom);
      b  = W'($urandom);
      ci = 1'($urandom_range(0, 1));
      do_op(a, b, ci, lat, busy_bad);
      check_result("random", a, b, ci, lat, busy_bad);
    end
  endtask

  task automatic test_back_to_back();
    int lat, gap;
    logic held_ok;
    @(negedge CLK);
    A = 8'h5A; B = 8'h0F; CIN = 1'b1; START = 1'b1;
    @(negedge CLK);
    START = 1'b0; lat = 0;
    repeat (3) begin @(negedge CLK); lat++; end
    A = 8'h11; B = 8'h22; CIN = 1'b0; START = 1'b1;
    @(negedge CLK); lat++;
    START = 1'b0;
    while (!DONE && lat < 3 * W) begin @(negedge CLK); lat++; end
    n_cmp++;
    if (lat != W || {COUT, SUM} !== ref_add(8'h5A, 8'h0F, 1'b1)) begin
      n_bad++;
      $display("FAIL ignore_start: got lat=%0d result=%h want lat=%0d result=%h",
               lat, {COUT, SUM}, W, ref_add(8'h5A, 8'h0F, 1'b1));
    end
    // Hold START through the DONE cycle.
    A = 8'h10; B = 8'h20; CIN = 1'b0; START = 1'b1;
    @(negedge CLK);
    START = 1'b0; gap = 1; held_ok = 1'b1;
    while (!DONE && gap < 3 * W) begin
      if ({COUT, SUM} !== ref_add(8'h5A, 8'h0F, 1'b1)) held_ok = 1'b0;
      @(negedge CLK); gap++;
    end
    n_cmp++;
    if (gap != W + 1) begin
      n_bad++;
      $display("FAIL b2b_gap: got %0d want %0d", gap, W + 1);
    end
    n_cmp++;
    if ({COUT, SUM} !== 9'h030) begin
      n_bad++;
      $display("FAIL b2b_sum: got %h want 030", {COUT, SUM});
    end
    n_cmp++;
    if (held_ok !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_hold_while_busy: got %b want 1", held_ok);
    end
  endtask

  task automatic test_reset_midop();
    int lat, n_done, n_busy, busy_bad;
    @(negedge CLK);
    A = 8'hC3; B = 8'h5D; CIN = 1'b1; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    repeat (4) @(negedge CLK);
    #2 RST_N = 1'b0;
    #1;
    n_cmp++;
    if ({BUSY, DONE, COUT, SUM} !== {3'b000, {W{1'b0}}}) begin
      n_bad++;
      $display("FAIL reset_midop: got busy=%b done=%b cout=%b sum=%h want all 0", BUSY, DONE, COUT, SUM);
    end
`ifdef SERIAL_ADDER_OVF_EN
    n_cmp++;
    if (OVF !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_midop_ovf: got %b want 0", OVF);
    end
`endif
    @(negedge CLK);
    RST_N = 1'b1;
    n_done = 0; n_busy = 0;
    repeat (3 * W) begin
      @(negedge CLK);
      if (DONE) n_done++;
      if (BUSY) n_busy++;
    end
    n_cmp++;
    if (n_done != 0 || n_busy != 0) begin
      n_bad++;
      $display("FAIL post_reset_idle: got done=%0d busy=%0d cycles want 0/0", n_done, n_busy);
    end
    do_op(8'h80, 8'h80, 1'b0, lat, busy_bad);
    check_result("after_reset", 8'h80, 8'h80, 1'b0, lat, busy_bad);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_midop();
    repeat (2) @(negedge CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
